// File: rtl/wb_pipe_master_bridge.sv
// Core valid/ready request port to Wishbone B4 pipelined master with
// in-order response tagging, optional response register and bus-timeout abort.
module wb_pipe_master_bridge #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int RESP_REG        = 1,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic                               clk_core,
  input  logic                               rst_core,
  input  logic                               req_valid_i,
  output logic                               req_ready_o,
  input  logic                               req_we_i,
  input  logic [ADDR_WIDTH-1:0]              req_addr_i,
  input  logic [DATA_WIDTH-1:0]              req_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]            req_sel_i,
  output logic                               rsp_valid_o,
  output logic [DATA_WIDTH-1:0]              rsp_rdata_o,
  output logic                               rsp_err_o,
  output logic                               rsp_we_o,
  output logic                               wb_cyc_o,
  output logic                               wb_stb_o,
  output logic                               wb_we_o,
  output logic [DATA_WIDTH/8-1:0]            wb_sel_o,
  output logic [ADDR_WIDTH-1:0]              wb_addr_o,
  output logic [DATA_WIDTH-1:0]              wb_data_o,
  input  logic [DATA_WIDTH-1:0]              wb_data_i,
  input  logic                               wb_ack_i,
  input  logic                               wb_err_i,
  input  logic                               wb_stall_i,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o
);
  localparam int SEL_WIDTH = DATA_WIDTH / 8;
  localparam int CNT_WIDTH = $clog2(MAX_OUTSTANDING) + 1;
  localparam int PTR_WIDTH = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int TMO_WIDTH = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = CNT_WIDTH'(MAX_OUTSTANDING);
  localparam logic [PTR_WIDTH-1:0] PTR_LAST  = PTR_WIDTH'(MAX_OUTSTANDING - 1);
  localparam logic [TMO_WIDTH-1:0] TMO_LIMIT = TMO_WIDTH'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_ABORT} state_t;

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [TMO_WIDTH-1:0]  tmo_q, tmo_d;
  logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                  stb_q, stb_d;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [SEL_WIDTH-1:0]  sel_q;
  logic                  tag_mem_q [MAX_OUTSTANDING];

  logic                  accept, slave_take, bus_done, abort_pop, rsp_fire;
  logic                  rsp_err, rsp_we, pop_tag;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  assign wb_stb_o    = stb_q & (state_q != ST_ABORT);
  assign wb_cyc_o    = (cnt_q != '0) & (state_q != ST_ABORT);
  assign wb_we_o     = we_q;
  assign wb_sel_o    = sel_q;
  assign wb_addr_o   = addr_q;
  assign wb_data_o   = data_q;
  assign req_ready_o = (state_q != ST_ABORT) & (cnt_q < CNT_MAX) & (!wb_stb_o | !wb_stall_i);
  assign outstanding_o = cnt_q;

  assign accept     = req_valid_i & req_ready_o;
  assign slave_take = wb_stb_o & !wb_stall_i;
  assign bus_done   = (wb_ack_i | wb_err_i) & (cnt_q != '0) & (state_q != ST_ABORT);
  // While aborting, the tag FIFO drains one entry per cycle as error responses.
  assign abort_pop  = (state_q == ST_ABORT) & (cnt_q != '0);
  assign rsp_fire   = bus_done | abort_pop;
  assign pop_tag    = tag_mem_q[rd_ptr_q];
  assign rsp_err    = abort_pop | (bus_done & wb_err_i);
  assign rsp_we     = rsp_fire & pop_tag;
  assign rsp_rdata  = (bus_done & !wb_err_i) ? wb_data_i : '0;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tmo_d    = '0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    stb_d    = stb_q;

    if (accept && !rsp_fire) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end else if (!accept && rsp_fire) begin
      cnt_d = cnt_q - CNT_WIDTH'(1);
    end

    if (accept) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_WIDTH'(1);
    end
    if (rsp_fire) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_WIDTH'(1);
    end

    if (accept) begin
      stb_d = 1'b1;
    end else if (slave_take) begin
      stb_d = 1'b0;
    end

    if ((TIMEOUT_CYCLES != 0) && (cnt_q != '0) && !bus_done && (state_q != ST_ABORT)) begin
      tmo_d = tmo_q + TMO_WIDTH'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if ((TIMEOUT_CYCLES != 0) && (tmo_d == TMO_LIMIT)) begin
          state_d = ST_ABORT;
        end else if (cnt_d == '0) begin
          state_d = ST_IDLE;
        end
      end
      ST_ABORT: begin
        stb_d = 1'b0;
        if (cnt_d == '0) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_core or posedge rst_core) begin
    if (rst_core) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      tmo_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      stb_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      stb_q    <= stb_d;
    end
  end

  // Strobe-stage payload only loads on accept, so it stays put while stalled.
  always_ff @(posedge clk_core or posedge rst_core) begin
    if (rst_core) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      sel_q  <= '0;
    end else if (accept) begin
      we_q   <= req_we_i;
      addr_q <= req_addr_i;
      data_q <= req_wdata_i;
      sel_q  <= req_sel_i;
    end
  end

  always_ff @(posedge clk_core) begin
    if (accept) begin
      tag_mem_q[wr_ptr_q] <= req_we_i;
    end
  end

  generate
    if (RESP_REG != 0) begin : g_rsp_reg
      logic                  rsp_valid_q, rsp_err_q, rsp_we_q;
      logic [DATA_WIDTH-1:0] rsp_rdata_q;

      always_ff @(posedge clk_core or posedge rst_core) begin
        if (rst_core) begin
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          rsp_we_q    <= 1'b0;
          rsp_rdata_q <= '0;
        end else begin
          rsp_valid_q <= rsp_fire;
          rsp_err_q   <= rsp_err;
          rsp_we_q    <= rsp_we;
          rsp_rdata_q <= rsp_rdata;
        end
      end

      assign rsp_valid_o = rsp_valid_q;
      assign rsp_err_o   = rsp_err_q;
      assign rsp_we_o    = rsp_we_q;
      assign rsp_rdata_o = rsp_rdata_q;
    end else begin : g_rsp_comb
      assign rsp_valid_o = rsp_fire;
      assign rsp_err_o   = rsp_err;
      assign rsp_we_o    = rsp_we;
      assign rsp_rdata_o = rsp_rdata;
    end
  endgenerate

endmodule

// File: tb/tb_wb_pipe_master_bridge.sv
// Scoreboard bench for wb_pipe_master_bridge: scripted pipelined slave,
// expected responses queued at request acceptance and popped on rsp_valid_o.
module tb_wb_pipe_master_bridge;
  logic        clk_core = 1'b0;
  logic        rst_core;
  logic        req_valid_i, req_ready_o, req_we_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic [3:0]  req_sel_i;
  logic        rsp_valid_o, rsp_err_o, rsp_we_o;
  logic [31:0] rsp_rdata_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_addr_o, wb_data_o, wb_data_i;
  logic        wb_ack_i, wb_err_i, wb_stall_i;
  logic [2:0]  outstanding_o;

  always #5 clk_core = ~clk_core;

  wb_pipe_master_bridge #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(4), .RESP_REG(1), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_core(clk_core), .rst_core(rst_core),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_sel_i(req_sel_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o), .rsp_we_o(rsp_we_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
    .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o), .wb_data_i(wb_data_i),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_stall_i(wb_stall_i),
    .outstanding_o(outstanding_o)
  );

  typedef struct { logic we; logic err; logic [31:0] rdata; } exp_t;
  typedef struct { logic [31:0] addr; int rdy; } pend_t;

  exp_t  exp_q[$];
  pend_t pend_q[$];

  int checks = 0;
  int failures = 0;
  int cyc_no = 0;
  int cyc_hi = 0;
  int stall_left = 0;
  int stall_seen = 0;
  int rsp_total = 0;
  int last_rsp_cyc = -100;
  int prev_rsp_cyc = -100;
  bit ack_en = 1'b1;
  bit late_ack_req = 1'b0;
  logic [31:0] stall_exp_addr = '0;
  logic [3:0]  stall_exp_sel = '0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
    return a * 32'd3 + 32'h1000_0001;
  endfunction

  initial forever begin
    @(posedge clk_core);
    cyc_no++;
  end

  // Pipelined slave: stalls on request, acks one cycle after each take, errors on addr[31].
  initial begin
    pend_t s;
    wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_stall_i = 1'b0; wb_data_i = '0;
    forever begin
      @(negedge clk_core);
      wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_stall_i = 1'b0; wb_data_i = '0;
      if (rst_core) begin
        pend_q.delete();
      end else begin
        if (wb_cyc_o) cyc_hi++;
        if (wb_stb_o && stall_left > 0) begin
          wb_stall_i = 1'b1;
          stall_left--;
          stall_seen++;
          check_eq("stall_addr_hold", wb_addr_o, stall_exp_addr);
          check_eq("stall_sel_hold", wb_sel_o, stall_exp_sel);
        end
        if (late_ack_req) begin
          pend_q.delete();
          late_ack_req = 1'b0;
          wb_ack_i = 1'b1;
          wb_data_i = 32'h1234_5678;
        end else if (ack_en && pend_q.size() > 0 && pend_q[0].rdy <= cyc_no) begin
          s = pend_q.pop_front();
          if (s.addr[31]) begin
            wb_err_i = 1'b1;
            wb_data_i = 32'hBAD0_BAD0;
          end else begin
            wb_ack_i = 1'b1;
            wb_data_i = rd_model(s.addr);
          end
        end
        if (wb_cyc_o && wb_stb_o && !wb_stall_i) begin
          s.addr = wb_addr_o;
          s.rdy = cyc_no + 1;
          pend_q.push_back(s);
        end
      end
    end
  end

  initial begin
    exp_t ce;
    forever begin
      @(negedge clk_core);
      #3;
      if (!rst_core && rsp_valid_o) begin
        if (exp_q.size() == 0) begin
          check_eq("rsp_unexpected", rsp_valid_o, 1'b0);
        end else begin
          ce = exp_q.pop_front();
          check_eq("rsp_rdata", rsp_rdata_o, ce.rdata);
          check_eq("rsp_err", rsp_err_o, ce.err);
          check_eq("rsp_we", rsp_we_o, ce.we);
          $display("rsp cyc=%0d we=%0b err=%0b rdata=%h", cyc_no, rsp_we_o, rsp_err_o, rsp_rdata_o);
        end
        rsp_total++;
        prev_rsp_cyc = last_rsp_cyc;
        last_rsp_cyc = cyc_no;
      end
    end
  end

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                        input logic [31:0] wdata, input bit force_err, output int acc_cyc);
    int n;
    exp_t e;
    @(negedge clk_core);
    #1;
    req_valid_i = 1'b1; req_we_i = we; req_addr_i = addr; req_sel_i = sel; req_wdata_i = wdata;
    #1;
    n = 0;
    while (!req_ready_o && n < 100) begin
      @(negedge clk_core);
      #2;
      n++;
    end
    if (!req_ready_o) begin
      check_eq("req_accept_timeout", req_ready_o, 1'b1);
      req_valid_i = 1'b0;
      acc_cyc = -1;
    end else begin
      e.we = we;
      e.err = force_err | addr[31];
      e.rdata = e.err ? 32'h0 : rd_model(addr);
      exp_q.push_back(e);
      @(posedge clk_core);
      #1;
      acc_cyc = cyc_no;
      req_valid_i = 1'b0;
      $display("req cyc=%0d we=%0b addr=%h sel=%h", acc_cyc, we, addr, sel);
    end
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk_core);
      #4;
      n++;
    end
    check_eq("drain_responses", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int a0, a1, a2, a3, ack_cyc, saved;
    bit seen;
    req_valid_i = 1'b0; req_we_i = 1'b0; req_addr_i = '0; req_wdata_i = '0; req_sel_i = '0;
    rst_core = 1'b1;
    repeat (3) @(posedge clk_core);
    @(negedge clk_core);
    #1;
    check_eq("rst_cyc", wb_cyc_o, 1'b0);
    check_eq("rst_stb", wb_stb_o, 1'b0);
    check_eq("rst_rsp_valid", rsp_valid_o, 1'b0);
    check_eq("rst_outstanding", outstanding_o, 3'd0);
    rst_core = 1'b0;
    #1;
    check_eq("rst_ready", req_ready_o, 1'b1);

    // single read, ack one cycle after stb
    do_req(1'b0, 32'h100, 4'hF, 32'h0, 1'b0, a0);
    seen = 1'b0;
    ack_cyc = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk_core);
      #2;
      if (wb_ack_i) begin
        seen = 1'b1;
        ack_cyc = cyc_no;
      end
    end
    check_eq("t1_ack_seen", seen, 1'b1);
    wait_drain(20);
    check_eq("t1_rsp_latency", last_rsp_cyc - ack_cyc, 1);
    check_eq("t1_cyc_low", wb_cyc_o, 1'b0);

    // four back-to-back writes with acks held off
    ack_en = 1'b0;
    do_req(1'b1, 32'h200, 4'hF, 32'hA000_0000, 1'b0, a0);
    do_req(1'b1, 32'h204, 4'hF, 32'hA000_0001, 1'b0, a1);
    do_req(1'b1, 32'h208, 4'hF, 32'hA000_0002, 1'b0, a2);
    do_req(1'b1, 32'h20C, 4'hF, 32'hA000_0003, 1'b0, a3);
    check_eq("t2_b2b_issue", a3 - a0, 3);
    @(negedge clk_core);
    #1;
    req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 32'h210;
    #1;
    check_eq("t2_ready_full", req_ready_o, 1'b0);
    check_eq("t2_outstanding", outstanding_o, 3'd4);
    req_valid_i = 1'b0;
    ack_en = 1'b1;
    wait_drain(40);
    check_eq("t2_outstanding_end", outstanding_o, 3'd0);

    // stall on the first of two reads
    stall_exp_addr = 32'h300;
    stall_exp_sel = 4'b0110;
    stall_seen = 0;
    stall_left = 3;
    do_req(1'b0, 32'h300, 4'b0110, 32'h0, 1'b0, a0);
    do_req(1'b0, 32'h304, 4'hF, 32'h0, 1'b0, a1);
    check_eq("t3_stall_cycles", stall_seen, 3);
    check_eq("t3_second_issue", a1 - a0, 4);
    wait_drain(40);

    // write answered by bus error
    do_req(1'b1, 32'h8000_0040, 4'hC, 32'h55, 1'b0, a0);
    wait_drain(40);
    check_eq("t4_outstanding", outstanding_o, 3'd0);

    // timeout abort with two reads outstanding
    ack_en = 1'b0;
    cyc_hi = 0;
    do_req(1'b0, 32'h400, 4'hF, 32'h0, 1'b1, a0);
    do_req(1'b0, 32'h404, 4'hF, 32'h0, 1'b1, a1);
    wait_drain(60);
    check_eq("t5_cyc_high_cycles", cyc_hi, 8);
    check_eq("t5_err_rsp_spacing", last_rsp_cyc - prev_rsp_cyc, 1);
    check_eq("t5_outstanding", outstanding_o, 3'd0);
    check_eq("t5_ready_back", req_ready_o, 1'b1);
    saved = rsp_total;
    late_ack_req = 1'b1;
    repeat (4) @(negedge clk_core);
    #4;
    check_eq("t5_late_ack_no_rsp", rsp_total, saved);
    check_eq("t5_late_ack_count", outstanding_o, 3'd0);
    ack_en = 1'b1;

    // reset with three requests outstanding
    ack_en = 1'b0;
    do_req(1'b0, 32'h500, 4'hF, 32'h0, 1'b0, a0);
    do_req(1'b0, 32'h504, 4'hF, 32'h0, 1'b0, a1);
    do_req(1'b0, 32'h508, 4'hF, 32'h0, 1'b0, a2);
    check_eq("t6_pre_rst_count", outstanding_o, 3'd3);
    @(negedge clk_core);
    #1;
    rst_core = 1'b1;
    exp_q.delete();
    #1;
    check_eq("t6_rst_cyc", wb_cyc_o, 1'b0);
    check_eq("t6_rst_stb", wb_stb_o, 1'b0);
    check_eq("t6_rst_rsp_valid", rsp_valid_o, 1'b0);
    check_eq("t6_rst_outstanding", outstanding_o, 3'd0);
    @(negedge clk_core);
    #1;
    rst_core = 1'b0;
    ack_en = 1'b1;
    do_req(1'b0, 32'h100, 4'hF, 32'h0, 1'b0, a0);
    wait_drain(40);
    check_eq("t6_outstanding_end", outstanding_o, 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/wb_pipe_master_bridge.md
Name: wb_pipe_master_bridge

Overview:
- Parametrised successor to the fixed single-slot core-to-Wishbone glue used in processorci_top wrappers.
- Converts a core-side valid/ready memory request port into a Wishbone B4 pipelined master.
- Supports configurable width, multiple outstanding transactions, an optional registered response stage, in-order response tagging, and a bus-timeout abort with error responses.
- One instance per core memory port (instruction or data) between the core and the Controller.

Parameters:
ADDR_WIDTH, 32, request/Wishbone address width
DATA_WIDTH, 32, data width; multiple of 8; SEL width = DATA_WIDTH/8
MAX_OUTSTANDING, 4, max accepted-but-unanswered requests; power of 2, 1..16
RESP_REG, 1, 0 = response combinational from wb_ack_i/wb_err_i; 1 = one register stage
TIMEOUT_CYCLES, 255, cycles without ack/err while outstanding before abort; 0 disables

Ports:
clk_core  in  1  core clock
rst_core  in  1  asynchronous active-high reset
req_valid_i  in  1  core request valid
req_ready_o  out  1  bridge accepts request this cycle
req_we_i  in  1  1 = write
req_addr_i  in  ADDR_WIDTH  request address
req_wdata_i  in  DATA_WIDTH  write data
req_sel_i  in  DATA_WIDTH/8  byte enables
rsp_valid_o  out  1  response pulse, one per accepted request, in order; no backpressure
rsp_rdata_o  out  DATA_WIDTH  read data (0 on error)
rsp_err_o  out  1  response is bus error or timeout
rsp_we_o  out  1  we bit of the request being answered
wb_cyc_o, wb_stb_o, wb_we_o  out  1  Wishbone cycle/strobe/write
wb_sel_o  out  DATA_WIDTH/8  Wishbone select
wb_addr_o  out  ADDR_WIDTH  Wishbone address
wb_data_o  out  DATA_WIDTH  Wishbone write data
wb_data_i  in  DATA_WIDTH  Wishbone read data
wb_ack_i, wb_err_i, wb_stall_i  in  1  Wishbone ack/err/stall
outstanding_o  out  $clog2(MAX_OUTSTANDING)+1  current outstanding count

Behaviour:
- Reset (async, active-high): all registered outputs 0; count 0; tag FIFO empty; state IDLE. After release, req_ready_o = 1.
- Clock and reset are fixed: one clock, clk_core; reset rst_core is asynchronous and active-high.
- States:
  - IDLE (count==0): goes to ACTIVE on accept.
  - ACTIVE (count>0): goes to IDLE when count returns to 0; goes to ABORT on timeout.
  - ABORT: goes to IDLE when the tag FIFO empties.
- Ready: req_ready_o = (state!=ABORT) & (count<MAX_OUTSTANDING) & (!wb_stb_o | !wb_stall_i).
- Accept (valid & ready):
  - Request registers into the strobe stage; wb_stb_o=1 from the next cycle.
  - wb_addr_o/data/sel/we are held stable while wb_stall_i=1.
  - stb drops after the slave accepts (stb & !stall) unless a new request was accepted in the same cycle, which gives back-to-back issue (1 req/cycle).
  - The we bit is pushed into the tag FIFO (depth MAX_OUTSTANDING).
  - count++.
- wb_cyc_o = (count!=0) & (state!=ABORT).
- Completion (wb_ack_i | wb_err_i) while count>0 and state!=ABORT:
  - Pop the FIFO; count--.
  - Response fields: rsp_err_o=wb_err_i, rsp_rdata_o=wb_data_i (0 if err), rsp_we_o=popped tag.
  - Latency: same cycle with RESP_REG=0, +1 cycle with RESP_REG=1.
  - ack and err together count as err.
- Accept and completion in the same cycle: count unchanged; FIFO push and pop both occur. No overflow is possible, since a push requires count<MAX.
- Spurious ack/err with count==0: ignored, no response.
- Timeout:
  - Counter clears on any completion or when count==0; increments otherwise.
  - When it equals TIMEOUT_CYCLES (≠0), enter ABORT.
  - In ABORT: wb_cyc_o and wb_stb_o are 0 immediately.
  - One error response (rsp_err_o=1, rdata 0) is emitted per cycle per FIFO entry, honouring RESP_REG latency.
  - count decrements to 0; late ack/err are ignored.
- Reset mid-transaction: cyc and stb drop asynchronously; no responses are emitted for lost requests.
- Widths: count saturation is impossible by construction; sel width is DATA_WIDTH/8 throughout.

Test Plan:
- Single read, RESP_REG=1, slave acks 1 cycle after stb with data 0xDEADBEEF -> rsp_valid_o 1 cycle after ack; rdata 0xDEADBEEF, err 0, we 0; cyc low afterwards.
- 4 back-to-back writes, MAX_OUTSTANDING=4, slave delays all acks -> req_ready_o low on the 5th request; outstanding_o=4; 4 responses in order with rsp_we_o=1.
- wb_stall_i high 3 cycles on the first of two reads -> addr/sel held constant across the stall; second stb follows the stall; responses in issue order.
- Write with wb_err_i -> one response, rsp_err_o=1, rdata 0; count returns to 0.
- TIMEOUT_CYCLES=8, 2 reads outstanding, no ack -> cyc drops 8 cycles after the last activity; 2 error responses on consecutive cycles; a late ack afterwards produces no response; ready returns.
- rst_core asserted with 3 outstanding -> cyc, stb and rsp_valid drop immediately; outstanding_o=0; normal read succeeds after release.
